acc_force_collector: RTL
========================

// Module: acc_force_collector
// PURPOSE
//  Downstream stage of the 7 per-cell partial force accumulators in the RL LJ evaluation unit.
//  Captures each accumulator's 1-cycle done pulse (id + x/y/z force) into a per-lane FIFO.
//  Round-robin merges the FIFOs into one valid/ready stream feeding the force cache write port.
//  No done pulse is lost unless its lane FIFO overflows; overflow is flagged.
// PARAMETERS
//  DATA_WIDTH         32  IEEE-754 single-precision force word width
//  PARTICLE_ID_WIDTH  20  particle index field width
//  CELL_ID_WIDTH      3   per-axis cell coordinate width; full id = 3*CELL_ID_WIDTH+PARTICLE_ID_WIDTH
//  NUM_ACC            7   number of accumulator lanes (max 8)
//  FIFO_DEPTH         4   entries per lane FIFO, power of 2, >=2
// PORTS
//  clk          in   1                clock
//  rst          in   1                synchronous, active-high reset
//  in_valid     in   NUM_ACC          per-lane done pulse from accumulator i
//  in_id        in   NUM_ACC*ID_W     lane i id at [i*ID_W +: ID_W], {cell_id, particle}
//  in_force_x   in   NUM_ACC*DATA_W   lane i force x, same packing (also _y, _z)
//  out_valid    out  1                output entry valid
//  out_ready    in   1                force cache accepts entry
//  out_id       out  ID_W             id of output entry
//  out_force_x  out  DATA_W           accumulated force x (also _y, _z)
//  out_src      out  3                lane index the entry came from
//  overflow     out  NUM_ACC          sticky: lane i dropped a pulse on full FIFO
//  busy         out  1                any FIFO non-empty or out_valid high
// BEHAVIOUR
//  Reset: all FIFOs emptied, rr pointer=0, out_valid=0, out_id/out_force_*/out_src=0, overflow=0.
//  Write: lane i pushes {id,fx,fy,fz} at edge where in_valid[i]=1 and lane not full.
//  Full: push with full & no same-cycle pop -> entry dropped, overflow[i]<=1 until rst.
//  Full + same-cycle pop of lane i -> push accepted, count unchanged.
//  Pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
//  Output reg load condition: load = ~out_valid | out_ready.
//  Arbiter: when load, grant first non-empty lane scanning from rr+1 (mod NUM_ACC) upward;
//   granted lane popped, entry + lane index registered, out_valid<=1, rr<=granted lane.
//  No lane non-empty while load -> out_valid<=0.
//  Stall: out_valid & ~out_ready -> all out_* held stable, no pop.
//  Latency: pulse at edge t -> earliest out_valid at edge t+1 (FIFO has 1-cycle read-through
//   of head; empty FIFO written at t is grantable in cycle t+1... registered at t+1 edge is
//   NOT allowed: head becomes visible after edge t, registered at edge t+1).
//  Throughput: one entry per cycle with out_ready held high.
//  Forces passed bit-exact; no arithmetic on payload.
//  rst mid-stream: buffered entries discarded, out_valid drops at the reset edge.
// CONFIGURATION
//  ACC_FORCE_COLLECTOR_ZERO_FILTER_EN defined:
//   pulses whose fx,fy,fz are all +0.0 or -0.0 (exponent&mantissa==0) are not pushed and
//   never set overflow (removes post-reset and empty-neighbour done pulses).
//  Not defined: every in_valid pulse is pushed regardless of payload.
// TESTING
//  1 Lane 3 pulse id=0x0_0042, fx=0x3F800000 at t, out_ready=1 -> out_valid at t+1,
//    out_src=3, payload exact, one beat only.
//  2 All 7 lanes pulse same cycle, out_ready=1 -> 7 beats on consecutive cycles,
//    out_src order 1,2,3,4,5,6,0 (rr reset 0), busy low after last.
//  3 Lane 0 pulses 6 cycles straight, out_ready=0 -> 4 buffered + 1 in out reg? no:
//    out reg holds 1, FIFO 4, 6th dropped, overflow[0]=1; release ready -> 5 beats.
//  4 out_ready toggled 1/0 every cycle with 3 lanes active -> payload stable while stalled,
//    no loss/duplication, beat count = pulses.
//  5 rst asserted with 3 entries buffered -> next cycle out_valid=0, busy=0, overflow=0.
//  6 Macro on: pulse with fx=fy=fz=0x80000000 -> no beat; fx=0x00000001 -> beat. Macro off:
//    both produce beats.

Source files
------------

// File: rtl/acc_force_collector_if.sv
// acc_force_collector_if
//   Bundles the collector's lane-input and merged-output signals.
//   Signal names match the original flat port list of acc_force_collector.
//   Inputs to the collector:
//     in_valid     [NUM_ACC]          per-lane done pulse
//     in_id        [NUM_ACC*ID_W]     lane i id at [i*ID_W +: ID_W], {cell_id, particle}
//     in_force_x/y/z [NUM_ACC*DATA_W] lane i force words, same packing
//     out_ready                       force cache accepts the current entry
//   Outputs from the collector:
//     out_valid, out_id, out_force_x/y/z, out_src (lane index),
//     overflow [NUM_ACC] (sticky drop flags), busy
//   Modports: master = accumulators + force cache side, slave = collector.
interface acc_force_collector_if #(
    parameter int DATA_WIDTH        = 32,
    parameter int PARTICLE_ID_WIDTH = 20,
    parameter int CELL_ID_WIDTH     = 3,
    parameter int NUM_ACC           = 7
);
    localparam int ID_W = 3 * CELL_ID_WIDTH + PARTICLE_ID_WIDTH;

    logic [NUM_ACC-1:0]            in_valid;
    logic [NUM_ACC*ID_W-1:0]       in_id;
    logic [NUM_ACC*DATA_WIDTH-1:0] in_force_x;
    logic [NUM_ACC*DATA_WIDTH-1:0] in_force_y;
    logic [NUM_ACC*DATA_WIDTH-1:0] in_force_z;
    logic                          out_valid;
    logic                          out_ready;
    logic [ID_W-1:0]               out_id;
    logic [DATA_WIDTH-1:0]         out_force_x;
    logic [DATA_WIDTH-1:0]         out_force_y;
    logic [DATA_WIDTH-1:0]         out_force_z;
    logic [2:0]                    out_src;
    logic [NUM_ACC-1:0]            overflow;
    logic                          busy;

    modport master (
        output in_valid, in_id, in_force_x, in_force_y, in_force_z, out_ready,
        input  out_valid, out_id, out_force_x, out_force_y, out_force_z,
               out_src, overflow, busy
    );

    modport slave (
        input  in_valid, in_id, in_force_x, in_force_y, in_force_z, out_ready,
        output out_valid, out_id, out_force_x, out_force_y, out_force_z,
               out_src, overflow, busy
    );
endinterface

// File: rtl/acc_force_collector.sv
// acc_force_collector
//   Captures the 1-cycle done pulses of NUM_ACC partial force accumulators into
//   per-lane FIFOs and round-robin merges them into one valid/ready stream for
//   the force cache write port. A pulse arriving at a full lane FIFO (with no
//   same-cycle pop of that lane) is dropped and sets that lane's sticky overflow.
//   Ports:
//     clk  clock
//     rst  synchronous, active-high reset
//     bus  acc_force_collector_if.slave (lane inputs, merged output, status)
//   Optional feature: define ACC_FORCE_COLLECTOR_ZERO_FILTER_EN to discard pulses
//   whose three force words are all +/-0.0; such pulses never set overflow.
module acc_force_collector #(
    parameter int DATA_WIDTH        = 32,
    parameter int PARTICLE_ID_WIDTH = 20,
    parameter int CELL_ID_WIDTH     = 3,
    parameter int NUM_ACC           = 7,
    parameter int FIFO_DEPTH        = 4
) (
    input logic                 clk,
    input logic                 rst,
    acc_force_collector_if.slave bus
);
    localparam int ID_W  = 3 * CELL_ID_WIDTH + PARTICLE_ID_WIDTH;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SRC_W = 3;
    localparam int unsigned LANES = NUM_ACC;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [ID_W-1:0]       id;
        logic [DATA_WIDTH-1:0] fx;
        logic [DATA_WIDTH-1:0] fy;
        logic [DATA_WIDTH-1:0] fz;
    } entry_t;

    entry_t             mem     [NUM_ACC][FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr  [NUM_ACC];
    logic [PTR_W-1:0]   rd_ptr  [NUM_ACC];
    logic [CNT_W-1:0]   count   [NUM_ACC];
    entry_t             lane_in [NUM_ACC];
    entry_t             head    [NUM_ACC];

    logic [NUM_ACC-1:0] non_empty;
    logic [NUM_ACC-1:0] full;
    logic [NUM_ACC-1:0] push_req;
    logic [NUM_ACC-1:0] push;
    logic [NUM_ACC-1:0] drop;
    logic [NUM_ACC-1:0] pop;

    logic               load;
    logic               grant_valid;
    logic [SRC_W-1:0]   grant_idx;
    int unsigned        scan;

    logic [SRC_W-1:0]   rr;
    logic               out_valid_q;
    entry_t             out_entry_q;
    logic [SRC_W-1:0]   out_src_q;
    logic [NUM_ACC-1:0] overflow_q;

    // Lane unpacking, optional zero filtering and FIFO status.
    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_in[i] = {bus.in_id[i*ID_W +: ID_W],
                          bus.in_force_x[i*DATA_WIDTH +: DATA_WIDTH],
                          bus.in_force_y[i*DATA_WIDTH +: DATA_WIDTH],
                          bus.in_force_z[i*DATA_WIDTH +: DATA_WIDTH]};
`ifdef ACC_FORCE_COLLECTOR_ZERO_FILTER_EN
            // Sign bit ignored: both +0.0 and -0.0 count as zero force.
            push_req[i] = bus.in_valid[i] &&
                          !((lane_in[i].fx[DATA_WIDTH-2:0] == '0) &&
                            (lane_in[i].fy[DATA_WIDTH-2:0] == '0) &&
                            (lane_in[i].fz[DATA_WIDTH-2:0] == '0));
`else
            push_req[i] = bus.in_valid[i];
`endif
            head[i]      = mem[i][rd_ptr[i]];
            non_empty[i] = (count[i] != '0);
            full[i]      = (count[i] == FULL_COUNT);
        end
    end

    // Round-robin arbiter: scan upward starting one past the last granted lane.
    always_comb begin
        load        = !out_valid_q || bus.out_ready;
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan        = 0;
        for (int unsigned k = 1; k <= LANES; k++) begin
            scan = 32'(rr) + k;
            if (scan >= LANES) scan = scan - LANES;
            if (!grant_valid && non_empty[SRC_W'(scan)]) begin
                grant_valid = 1'b1;
                grant_idx   = SRC_W'(scan);
            end
        end
        pop = '0;
        if (load && grant_valid) pop[grant_idx] = 1'b1;
    end

    // A full lane still accepts a push when it is popped in the same cycle.
    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            push[i] = push_req[i] && (!full[i] || pop[i]);
            drop[i] = push_req[i] && full[i] && !pop[i];
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < LANES; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= lane_in[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr          <= '0;
            out_valid_q <= 1'b0;
            out_entry_q <= '0;
            out_src_q   <= '0;
            overflow_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
                if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
                else if (!push[i] && pop[i]) count[i] <= count[i] - 1'b1;
            end
            overflow_q <= overflow_q | drop;
            if (load) begin
                out_valid_q <= grant_valid;
                if (grant_valid) begin
                    out_entry_q <= head[grant_idx];
                    out_src_q   <= grant_idx;
                    rr          <= grant_idx;
                end
            end
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_id      = out_entry_q.id;
    assign bus.out_force_x = out_entry_q.fx;
    assign bus.out_force_y = out_entry_q.fy;
    assign bus.out_force_z = out_entry_q.fz;
    assign bus.out_src     = out_src_q;
    assign bus.overflow    = overflow_q;
    assign bus.busy        = (|non_empty) || out_valid_q;
endmodule
